div_radix2: RTL and testbench

// - Multi-cycle restoring radix-2 divider feeding the alpha-pipe HI/LO path.
// - Accepts DIV/DIVU requests from the ALU and returns {remainder, quotient}.
// - The ALU commits the result on the rising edge of done.
// - Replaces the single-step divider with an abortable, operand-latching, 34-cycle unit.

---
 rtl/mdu_pkg.sv | 27 ++
 rtl/div_radix2.sv | 167 ++++++++++++++++
 tb/tb_div_radix2.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_pkg
//  Description : Shared types and constants for the multiply/divide unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    // Divider request encoding as driven by the ALU.
    typedef enum logic [1:0] {
        DIV_NONE = 2'b00,
        DIV_U    = 2'b01,
        DIV_S    = 2'b10
    } div_op_t;

    // Divider control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    // One quotient bit is produced per CALC cycle.
    localparam int DIV_ITER = 32;

endpackage : mdu_pkg
`default_nettype wire

// File: rtl/div_radix2.sv
`default_nettype none
// ============================================================================
//  Module      : div_radix2
//  Description : Abortable multi-cycle restoring radix-2 divider. Latches the
//                operands on start, produces one quotient bit per cycle and
//                applies sign correction in a final FIX cycle.
//                result = {remainder, quotient}.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_radix2
    import mdu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit ZERO_FAST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           div_op,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic [2*WIDTH-1:0]   result,
    output logic                 done
);

    localparam int               CNT_W    = $clog2(DIV_ITER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITER - 1);

    div_state_t         state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [WIDTH-1:0]   rem_q,     rem_d;
    logic [WIDTH-1:0]   quo_q,     quo_d;
    logic [WIDTH-1:0]   dvsr_q,    dvsr_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic               zero_q,    zero_d;
    logic [2*WIDTH-1:0] result_q,  result_d;
    logic               done_q,    done_d;

    // Request decode and operand magnitudes (two's complement, so the most
    // negative value maps onto itself and is read back as an exact unsigned).
    logic               w_start;
    logic               w_signed;
    logic               w_dvd_neg;
    logic               w_dvs_neg;
    logic [WIDTH-1:0]   w_abs_dvd;
    logic [WIDTH-1:0]   w_abs_dvs;
    logic               w_dvs_zero;

    // One restoring step: shift rem:quo left by one and trial-subtract.
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;

    // Sign-corrected outputs used in FIX.
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_start    = (div_op == DIV_U) || (div_op == DIV_S);
    assign w_signed   = (div_op == DIV_S);
    assign w_dvd_neg  = w_signed & dividend[WIDTH-1];
    assign w_dvs_neg  = w_signed & divisor[WIDTH-1];
    assign w_abs_dvd  = w_dvd_neg ? -dividend : dividend;
    assign w_abs_dvs  = w_dvs_neg ? -divisor  : divisor;
    assign w_dvs_zero = (divisor == '0);

    assign w_shift    = {rem_q, quo_q[WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, dvsr_q};

    // The remainder always carries the dividend sign, which also restores the
    // original dividend for a divide-by-zero (rem holds |dividend| then).
    assign w_quo_fix  = zero_q    ? '1      :
                        neg_quo_q ? -quo_q  : quo_q;
    assign w_rem_fix  = neg_rem_q ? -rem_q  : rem_q;

    // Next-state, datapath and result update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        zero_d    = zero_q;
        result_d  = result_q;
        done_d    = (state_q == IDLE);

        case (state_q)
            IDLE: begin
                if (!abort && w_start) begin
                    dvsr_d    = w_abs_dvs;
                    quo_d     = w_abs_dvd;
                    neg_quo_d = w_dvd_neg ^ w_dvs_neg;
                    neg_rem_d = w_dvd_neg;
                    zero_d    = w_dvs_zero;
                    cnt_d     = CNT_LAST;
                    if (w_dvs_zero && ZERO_FAST) begin
                        // No iterations: preload the magnitude FIX expects.
                        rem_d   = w_abs_dvd;
                        state_d = FIX;
                    end else begin
                        rem_d   = '0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    if (!w_diff[WIDTH]) begin
                        rem_d = w_diff[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = w_shift[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!abort) begin
                    result_d = {w_rem_fix, w_quo_fix};
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset is asynchronous and immediate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            zero_q    <= 1'b0;
            result_q  <= '0;
            done_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            zero_q    <= zero_d;
            result_q  <= result_d;
            done_q    <= done_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;

endmodule : div_radix2
`default_nettype wire

// File: tb/tb_div_radix2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_radix2
//  Description : Directed self-checking bench for div_radix2 (WIDTH=32,
//                ZERO_FAST=1). Expected values are hand-computed constants.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_radix2;

    logic        clk;
    logic        rst_n;
    logic [1:0]  div_op;
    logic        abort;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [63:0] result;
    logic        done;

    int n_vec;
    int n_fail;

    div_radix2 #(
        .WIDTH     (32),
        .ZERO_FAST (1'b1)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .div_op   (div_op),
        .abort    (abort),
        .dividend (dividend),
        .divisor  (divisor),
        .result   (result),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request at the next edge T; returns just after edge T.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        div_op   = op;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        div_op   = 2'b00;
    endtask

    // From just after edge T: done must be 0 for T+1..T+lat-1, then 1 with
    // the expected result at T+lat.
    task automatic expect_result(input string tag, input int lat, input logic [63:0] exp);
        for (int i = 1; i < lat; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_busy"}, {63'd0, done}, 64'd0);
        end
        @(posedge clk);
        #1;
        check({tag, "_done"}, {63'd0, done}, 64'd1);
        check({tag, "_res"}, result, exp);
    endtask

    initial begin
        n_vec    = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        div_op   = 2'b00;
        abort    = 1'b0;
        dividend = '0;
        divisor  = '0;

        // Reset state
        #12;
        check("rst_done", {63'd0, done}, 64'd1);
        check("rst_result", result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic unsigned
        issue(2'b01, 32'd100, 32'd7);
        expect_result("divu_100_7", 34, 64'h00000002_0000000E);

        // Signed, all sign combinations
        issue(2'b10, 32'hFFFFFFF9, 32'd2);
        expect_result("div_m7_2", 34, 64'hFFFFFFFF_FFFFFFFD);
        issue(2'b10, 32'd100, 32'hFFFFFFF9);
        expect_result("div_100_m7", 34, 64'h00000002_FFFFFFF2);
        issue(2'b10, 32'hFFFFFF9C, 32'hFFFFFFF9);
        expect_result("div_m100_m7", 34, 64'hFFFFFFFE_0000000E);

        // Signed overflow wraps
        issue(2'b10, 32'h80000000, 32'hFFFFFFFF);
        expect_result("div_ovf", 34, 64'h00000000_80000000);

        // Unsigned extremes
        issue(2'b01, 32'hFFFFFFFF, 32'd1);
        expect_result("divu_max_1", 34, 64'h00000000_FFFFFFFF);

        // Divide by zero, fast path
        issue(2'b10, 32'hFFFFFFFB, 32'd0);
        expect_result("div_m5_0", 2, 64'hFFFFFFFB_FFFFFFFF);
        issue(2'b01, 32'd5, 32'd0);
        expect_result("divu_5_0", 2, 64'h00000005_FFFFFFFF);

        // Opcode 2'b11 is not a request
        issue(2'b11, 32'd9, 32'd3);
        @(posedge clk);
        #1;
        check("op11_idle", {63'd0, done}, 64'd1);
        check("op11_result", result, 64'h00000005_FFFFFFFF);

        // Abort in CALC at T+10: done at T+11, result untouched
        issue(2'b01, 32'd100, 32'd7);
        for (int i = 1; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("abort_busy", {63'd0, done}, 64'd0);
        end
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_t10", {63'd0, done}, 64'd0);
        @(posedge clk);
        #1;
        check("abort_done", {63'd0, done}, 64'd1);
        check("abort_result", result, 64'h00000005_FFFFFFFF);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("abort_idle", {63'd0, done}, 64'd1);
        end

        // Abort in IDLE beats a start
        @(negedge clk);
        abort = 1'b1;
        issue(2'b01, 32'd9, 32'd3);
        abort = 1'b0;
        @(posedge clk);
        #1;
        check("abort_idle_nostart", {63'd0, done}, 64'd1);
        @(posedge clk);
        #1;
        check("abort_idle_nostart2", {63'd0, done}, 64'd1);
        check("abort_idle_result", result, 64'h00000005_FFFFFFFF);

        // New op after abort
        issue(2'b01, 32'd9, 32'd3);
        expect_result("divu_9_3", 34, 64'h00000000_00000003);

        // Operands changed at T+5 are ignored
        issue(2'b01, 32'd100, 32'd7);
        repeat (4) @(posedge clk);
        #1;
        dividend = 32'd12345;
        divisor  = 32'd0;
        div_op   = 2'b10;
        expect_result("divu_latch", 30, 64'h00000002_0000000E);
        div_op   = 2'b00;
        @(posedge clk);
        #1;

        // Async reset mid-operation at T+15
        @(posedge clk);
        #1;
        issue(2'b01, 32'd100, 32'd7);
        repeat (14) @(posedge clk);
        @(negedge clk);
        check("prerst_busy", {63'd0, done}, 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_done", {63'd0, done}, 64'd1);
        check("midrst_result", result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("postrst_idle", {63'd0, done}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_div_radix2
`default_nettype wire
